// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: redirect requests and fetch accept in, PC and RAS status out.
// master = decode/execute/fetch requester, slave = the sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             pc_ready;
  logic             branch_en;
  logic             branch_rel;
  logic [WIDTH-1:0] branch_addr;
  logic             call_en;
  logic             ret_en;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    ras_depth;
  logic             ras_full;
  logic             ras_empty;
  logic             ras_err;

  modport master (
    output pc_ready, branch_en, branch_rel, branch_addr, call_en, ret_en,
    input  pc, ras_depth, ras_full, ras_empty, ras_err
  );

  modport slave (
    input  pc_ready, branch_en, branch_rel, branch_addr, call_en, ret_en,
    output pc, ras_depth, ras_full, ras_empty, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer with branch/call/ret and a circular return-address stack; redirects land one cycle later
// regardless of pc_ready, sequential advance only when pc_ready. PC_TRAP_EN: RAS faults jump to TRAP_VECTOR.
module pc_sequencer #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_VECTOR = '1
`endif
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] addr_t;

  addr_t                   pc_q, pc_d;
  logic [PW-1:0]           top_q, top_d;
  logic [DW-1:0]           depth_q, depth_d;
  logic                    err_q, err_d;
  logic [DEPTH-1:0][WIDTH-1:0] ras_q, ras_d;

  addr_t pc_inc;
  addr_t target;
  logic  push_en;
  logic  ras_full;
  logic  ras_empty;

  assign ras_full  = (depth_q == DW'(DEPTH));
  assign ras_empty = (depth_q == '0);

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_en = 1'b0;
    pc_inc  = pc_q + addr_t'(1);
    // A WIDTH-bit two's-complement offset added modulo 2**WIDTH equals the sign-extended sum.
    target  = bus.branch_rel ? (pc_q + bus.branch_addr) : bus.branch_addr;

    if (bus.ret_en) begin
      if (ras_empty) begin
        err_d = 1'b1;
`ifdef PC_TRAP_EN
        pc_d  = TRAP_VECTOR;
`else
        if (bus.pc_ready) pc_d = pc_inc;
`endif
      end else begin
        pc_d    = ras_q[top_q];
        top_d   = top_q - PW'(1);
        depth_d = depth_q - DW'(1);
      end
    end else if (bus.call_en) begin
      if (ras_full) begin
        err_d = 1'b1;
`ifdef PC_TRAP_EN
        pc_d  = TRAP_VECTOR;
`else
        // Overwrite the oldest entry: the circular pointer lands on it when full.
        push_en = 1'b1;
        top_d   = top_q + PW'(1);
        pc_d    = target;
`endif
      end else begin
        push_en = 1'b1;
        top_d   = top_q + PW'(1);
        depth_d = depth_q + DW'(1);
        pc_d    = target;
      end
    end else if (bus.branch_en) begin
      pc_d = target;
    end else if (bus.pc_ready) begin
      pc_d = pc_inc;
    end
  end

  always_comb begin
    ras_d = ras_q;
    if (push_en) ras_d[top_d] = pc_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc        = pc_q;
  assign bus.ras_depth = depth_q;
  assign bus.ras_full  = ras_full;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (WIDTH=8, DEPTH=4); expectations follow PC_TRAP_EN when defined.
module tb_pc_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_sequencer_if #(.WIDTH(8), .DEPTH(4)) bus ();

  pc_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock once, then sample 1ns after the edge and return to idle.
  task automatic cyc(input logic rdy, input logic br, input logic rel,
                     input logic cl, input logic rt, input logic [7:0] addr);
    bus.pc_ready    = rdy;
    bus.branch_en   = br;
    bus.branch_rel  = rel;
    bus.call_en     = cl;
    bus.ret_en      = rt;
    bus.branch_addr = addr;
    @(posedge clk);
    #1;
    bus.pc_ready    = 1'b0;
    bus.branch_en   = 1'b0;
    bus.branch_rel  = 1'b0;
    bus.call_en     = 1'b0;
    bus.ret_en      = 1'b0;
    bus.branch_addr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
  endtask

  logic [7:0] ret_exp [4];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset state
    do_reset();
    chk("rst_pc", bus.pc, 0);
    chk("rst_depth", bus.ras_depth, 0);
    chk("rst_empty", bus.ras_empty, 1);
    chk("rst_full", bus.ras_full, 0);
    chk("rst_err", bus.ras_err, 0);

    // Sequential advance, hold, mid-run reset
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("seq_pc", bus.pc, i);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("hold_pc", bus.pc, 3);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd99);
    reset = 1'b0;
    chk("midrst_pc", bus.pc, 0);

    // Wrap and relative branches
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd254);
    chk("abs_br", bus.pc, 254);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("seq_255", bus.pc, 255);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("wrap_0", bus.pc, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    chk("abs_br2", bus.pc, 2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFC);
    chk("rel_back", bus.pc, 254);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
    chk("rel_fwd_wrap", bus.pc, 3);

    // Single call/return
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40);
    chk("call_pc", bus.pc, 40);
    chk("call_depth", bus.ras_depth, 1);
    chk("call_empty", bus.ras_empty, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("ret_pc", bus.pc, 11);
    chk("ret_empty", bus.ras_empty, 1);
    chk("ret_depth", bus.ras_depth, 0);
    chk("ret_err", bus.ras_err, 0);

    // ret beats call and branch; redirects ignore pc_ready
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd19);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd100);
    chk("pri_setup_pc", bus.pc, 100);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd50);
    chk("pri_pc", bus.pc, 20);
    chk("pri_depth", bus.ras_depth, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd77);
    chk("br_noready", bus.pc, 77);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("idle_hold", bus.pc, 77);

    // Nested calls and overflow
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd10);
    chk("call_rel", bus.pc, 20);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd30);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd50);
    chk("fill_full", bus.ras_full, 1);
    chk("fill_depth", bus.ras_depth, 4);
    chk("fill_err", bus.ras_err, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd60);
    chk("ovf_err", bus.ras_err, 1);
    chk("ovf_full", bus.ras_full, 1);
    chk("ovf_depth", bus.ras_depth, 4);
`ifdef PC_TRAP_EN
    chk("ovf_pc", bus.pc, 255);
    ret_exp = '{8'd41, 8'd31, 8'd21, 8'd11};
`else
    chk("ovf_pc", bus.pc, 60);
    ret_exp = '{8'd51, 8'd41, 8'd31, 8'd21};
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      chk("nest_ret_pc", bus.pc, ret_exp[i]);
      chk("nest_ret_depth", bus.ras_depth, 3 - i);
    end
    chk("nest_empty", bus.ras_empty, 1);
    chk("nest_err_sticky", bus.ras_err, 1);

    // Underflow
    do_reset();
    chk("rst_clears_err", bus.ras_err, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("unf_err", bus.ras_err, 1);
    chk("unf_depth", bus.ras_depth, 0);
`ifdef PC_TRAP_EN
    chk("unf_pc", bus.pc, 255);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("unf_next_pc", bus.pc, 0);
`else
    chk("unf_pc", bus.pc, 8);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("unf_next_pc", bus.pc, 9);
`endif
    chk("unf_err_sticky", bus.ras_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
